// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: funct codes and FSM states.
package mdu_pkg;

    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MTLO  = 6'b010011;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_e;

    function automatic logic is_iter_op(input logic [5:0] f);
        return (f == FN_MULT) || (f == FN_MULTU) || (f == FN_DIV) || (f == FN_DIVU);
    endfunction

endpackage

// File: rtl/mdu_signfix.sv
// Turns the magnitude result of the iterative core into the architectural HI/LO value,
// applying sign correction and the divide-by-zero / signed-overflow overrides.
module mdu_signfix
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] raw_hi,
    input  logic [WIDTH-1:0] raw_lo,
    output logic [WIDTH-1:0] fix_hi,
    output logic [WIDTH-1:0] fix_lo
);

    localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH - 1){1'b0}}};

    logic                   a_neg;
    logic                   b_neg;
    logic                   div_zero;
    logic                   div_ovf;
    logic [2*WIDTH-1:0]     prod;

    assign a_neg    = is_signed & op_a[WIDTH-1];
    assign b_neg    = is_signed & op_b[WIDTH-1];
    assign div_zero = (op_b == '0);
    assign div_ovf  = is_signed && (op_a == MinNeg) && (op_b == '1);
    assign prod     = {raw_hi, raw_lo};

    always_comb begin
        fix_hi = raw_hi;
        fix_lo = raw_lo;
        if (!is_div) begin
            if (a_neg ^ b_neg) begin
                {fix_hi, fix_lo} = -prod;
            end
        end else if (div_zero) begin
            fix_hi = op_a;
            fix_lo = '1;
        end else if (div_ovf) begin
            fix_hi = '0;
            fix_lo = MinNeg;
        end else begin
            // Quotient truncates toward zero; remainder takes the dividend's sign.
            fix_lo = (a_neg ^ b_neg) ? -raw_lo : raw_lo;
            fix_hi = a_neg ? -raw_hi : raw_hi;
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with private HI/LO: shift-add multiply and restoring divide,
// one bit per cycle on operand magnitudes, sign-corrected in a final FIX cycle.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]  acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0]  opnd_q, opnd_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic              is_div_q, is_div_d;
    logic              is_signed_q, is_signed_d;
    logic              done_q, done_d;

    logic              start_div;
    logic              start_signed;
    logic [WIDTH-1:0]  a_mag;
    logic [WIDTH-1:0]  b_mag;
    logic [WIDTH-1:0]  mul_addend;
    logic [WIDTH:0]    mul_sum;
    logic [WIDTH:0]    div_shift;
    logic [WIDTH:0]    div_diff;
    logic              div_ge;
    logic [WIDTH-1:0]  fix_hi;
    logic [WIDTH-1:0]  fix_lo;

    assign start_div    = (funct == FN_DIV) || (funct == FN_DIVU);
    assign start_signed = (funct == FN_MULT) || (funct == FN_DIV);
    assign a_mag        = (start_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag        = (start_signed && b[WIDTH-1]) ? -b : b;

    // Multiply: acc_hi accumulates the partial product, acc_lo holds the multiplier.
    assign mul_addend = acc_lo_q[0] ? opnd_q : '0;
    assign mul_sum    = {1'b0, acc_hi_q} + {1'b0, mul_addend};

    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
    assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_ge    = (div_shift >= {1'b0, opnd_q});

    mdu_signfix #(
        .WIDTH (WIDTH)
    ) u_signfix (
        .is_div    (is_div_q),
        .is_signed (is_signed_q),
        .op_a      (a_q),
        .op_b      (b_q),
        .raw_hi    (acc_hi_q),
        .raw_lo    (acc_lo_q),
        .fix_hi    (fix_hi),
        .fix_lo    (fix_lo)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_hi_d    = acc_hi_q;
        acc_lo_d    = acc_lo_q;
        opnd_d      = opnd_q;
        a_d         = a_q;
        b_d         = b_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        is_div_d    = is_div_q;
        is_signed_d = is_signed_q;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (is_iter_op(funct)) begin
                        state_d     = RUN;
                        cnt_d       = '0;
                        is_div_d    = start_div;
                        is_signed_d = start_signed;
                        a_d         = a;
                        b_d         = b;
                        acc_hi_d    = '0;
                        acc_lo_d    = start_div ? a_mag : b_mag;
                        opnd_d      = start_div ? b_mag : a_mag;
                    end else if (funct == FN_MTHI) begin
                        hi_d = a;
                    end else if (funct == FN_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            RUN: begin
                if (is_div_q) begin
                    acc_hi_d = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
                end else begin
                    {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                cnt_d   = '0;
                hi_d    = fix_hi;
                lo_d    = fix_lo;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            opnd_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            is_div_q    <= 1'b0;
            is_signed_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_hi_q    <= acc_hi_d;
            acc_lo_q    <= acc_lo_d;
            opnd_q      <= opnd_d;
            a_q         <= a_d;
            b_q         <= b_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            is_div_q    <= is_div_d;
            is_signed_q <= is_signed_d;
            done_q      <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative multiply/divide unit with its own HI/LO register pair for the multicycle MIPS datapath. It sits beside the ALU: the main controller issues an R-type `funct` plus operands with a one-cycle `start` strobe. The block decodes MULT/MULTU/DIV/DIVU/MTHI/MTLO itself and runs a shift-add or restoring-divide sequence. It reports completion with `busy`/`done`. It generalises the ALU control decode to a parametrised-width, multi-cycle operation class the single-cycle ALU cannot execute.

## Interface
- `WIDTH`, default 32: operand width. HI and LO are each `WIDTH` bits; `WIDTH` ≥ 2.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  operation request; sampled only while `busy`=0.
- `funct`  in  6  R-type function field; sampled with `start`.
- `a`  in  WIDTH  rs operand (multiplicand/dividend, MTHI/MTLO source).
- `b`  in  WIDTH  rt operand (multiplier/divisor).
- `busy`  out  1  iterative operation in progress.
- `done`  out  1  one-cycle pulse; new HI/LO is visible in the same cycle.
- `hi`  out  WIDTH  HI register (MFHI reads it directly).
- `lo`  out  WIDTH  LO register (MFLO reads it directly).

## Operation
- Decoded `funct` values:
  - 011000 MULT
  - 011001 MULTU
  - 011010 DIV
  - 011011 DIVU
  - 010001 MTHI
  - 010011 MTLO
  - Any other value with `start` has no effect.
- MTHI/MTLO, only when idle:
  - `hi`/`lo` is loaded from `a` at the sampling edge.
  - `busy` and `done` stay 0.
- MULT/DIV family, only when idle:
  - `a` and `b` are captured at the sampling edge; later operand changes are ignored.
  - Signed ops iterate on magnitudes; the sign is corrected in FIX.
- Multiply:
  - Unsigned shift-add, one multiplier bit per cycle.
  - The 2·WIDTH-bit product goes to {hi, lo}.
- Divide:
  - Restoring division, one quotient bit per cycle.
  - Quotient goes to `lo`, remainder to `hi`.
  - The remainder sign follows the dividend; the quotient truncates toward zero.
- Divide by zero (DIV or DIVU): `lo` = all ones, `hi` = `a`.
- Signed overflow, DIV with `a` = most negative and `b` = −1: `lo` = most negative, `hi` = 0.
- State machine:
  - IDLE → RUN on `start` with a MULT/DIV-family funct.
  - RUN holds for exactly WIDTH cycles, counted by an iteration counter of $clog2(WIDTH)+1 bits.
  - RUN → FIX.
  - FIX → IDLE; this transition writes hi/lo and asserts `done`.
- `start` while `busy`=1 is ignored, including MTHI/MTLO; the running operation is unaffected.
- Reset, including mid-operation: state IDLE, `hi`=`lo`=0, `busy`=0, `done`=0, counter 0. An aborted result is never written.

## Timing
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0.
- Cycle numbering: `start` is sampled at edge E0.
- Mult/div sequence:
  - `busy`=1 from after E0 through edge E(WIDTH+1).
  - At E(WIDTH+1), `hi`/`lo` update, `done`=1 for that one cycle, and `busy`=0.
  - Latency from the start edge to a visible result is WIDTH+1 cycles (33 for WIDTH=32).
  - A new `start` is accepted in the same cycle `done`=1.
- MTHI/MTLO: the result is visible one cycle after the sampling edge.
- `done` never stays high for two consecutive cycles unless a second op completes back-to-back. That cannot happen faster than WIDTH+1 cycles.

## Structure
- Package `mdu_pkg` holds:
  - the funct localparams (FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_MTHI, FN_MTLO);
  - the state enum (IDLE, RUN, FIX).
- Natural sub-module: `mdu_signfix`, combinational.
  - Inputs: raw magnitude result, operand signs, op type.
  - Output: corrected {hi, lo}, including the div-by-zero and overflow overrides.
  - Instantiated once.
- Top level holds the FSM, counter, accumulator/remainder shift registers, and HI/LO.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → `done` 33 cycles after start edge; hi=0xFFFFFFFE, lo=0x00000001; `busy` high exactly 33 cycles.
- MULT a=0xFFFFFFFD (−3), b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1; repeat as MULTU → hi=0x00000004, lo=0xFFFFFFF1.
- Signed vs unsigned divide:
  - DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU a=7, b=2 → lo=3, hi=1.
- Divide corner cases:
  - DIV a=0x1234, b=0 → lo=0xFFFFFFFF, hi=0x1234.
  - DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Busy-time and reset behaviour:
  - MTHI a=0xDEADBEEF asserted 5 cycles into a MULTU 3×4 → ignored; final hi=0, lo=12.
  - Same op with `rst` at cycle 10 → next cycle busy=0, hi=lo=0, and no `done` ever.
- Idle move and back-to-back ops:
  - MTLO a=0xCAFEF00D while idle → lo=0xCAFEF00D one cycle later; busy/done stay 0.
  - A new DIVU issued in the `done` cycle is accepted.
